// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - sample input, start and result handshake bundle for sum_accumulator
interface sum_accumulator_if #(
  parameter int ACC_WIDTH = 8
);
  logic                 start;
  logic                 in_valid;
  logic [4:0]           in_sum;
  logic                 in_ready;
  logic                 result_valid;
  logic                 result_ready;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 overflow;
  logic                 busy;

  // Producer/consumer side: drives samples and start, takes the result
  modport master (
    output start, in_valid, in_sum, result_ready,
    input  in_ready, result_valid, acc_out, overflow, busy
  );

  // Accumulator side
  modport slave (
    input  start, in_valid, in_sum, result_ready,
    output in_ready, result_valid, acc_out, overflow, busy
  );
endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - saturating accumulator of NUM_SAMPLES adder sums with result handshake
module sum_accumulator #(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sum_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // One extra bit above the accumulator: its MSB flags saturation
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 xfer;

  // Unsaturated sum of the running total and the zero-extended sample
  always_comb begin
    sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH - 4){1'b0}}, bus.in_sum};
  end

  // Next-state and datapath decode; in_ready depends on state only
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        xfer = bus.in_valid;
        if (xfer) begin
          if (sum_ext[ACC_WIDTH]) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_ext[ACC_WIDTH-1:0];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs decoded from state
  always_comb begin
    bus.in_ready     = (state_q == S_ACCUM);
    bus.result_valid = (state_q == S_DONE);
    bus.busy         = (state_q != S_IDLE);
    bus.acc_out      = acc_q;
    bus.overflow     = ovf_q;
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - scoreboard bench for sum_accumulator at 8-bit and 6-bit widths
module tb_sum_accumulator;

  logic clk;
  logic rst_n;
  logic start;
  logic in_valid;
  logic [4:0] in_sum;
  logic result_ready;

  sum_accumulator_if #(.ACC_WIDTH(8)) if8 ();
  sum_accumulator_if #(.ACC_WIDTH(6)) if6 ();

  assign if8.start        = start;
  assign if8.in_valid     = in_valid;
  assign if8.in_sum       = in_sum;
  assign if8.result_ready = result_ready;
  assign if6.start        = start;
  assign if6.in_valid     = in_valid;
  assign if6.in_sum       = in_sum;
  assign if6.result_ready = result_ready;

  sum_accumulator #(.NUM_SAMPLES(4), .ACC_WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  sum_accumulator #(.NUM_SAMPLES(4), .ACC_WIDTH(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int acc8;
    int ov8;
    int acc6;
    int ov6;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int m_acc8, m_ov8, m_acc6, m_ov6, m_cnt;
  bit m_run;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_acc8 = 0; m_ov8 = 0; m_acc6 = 0; m_ov6 = 0; m_cnt = 0; m_run = 1'b1;
    check_eq("start_busy", int'(if8.busy), 1);
    check_eq("start_in_ready", int'(if8.in_ready), 1);
    check_eq("start_acc_clr", int'(if6.acc_out), 0);
    check_eq("start_ovf_clr", int'(if6.overflow), 0);
  endtask

  task automatic send_sample(input int v, input int bubbles);
    int s;
    for (int b = 0; b < bubbles; b++) tick();
    in_valid = 1'b1;
    in_sum   = 5'(v);
    tick();
    in_valid = 1'b0;
    s = m_acc8 + v;
    if (s > 255) begin m_acc8 = 255; m_ov8 = 1; end else m_acc8 = s;
    s = m_acc6 + v;
    if (s > 63) begin m_acc6 = 63; m_ov6 = 1; end else m_acc6 = s;
    m_cnt++;
    check_eq("acc8_step", int'(if8.acc_out), m_acc8);
    check_eq("acc6_step", int'(if6.acc_out), m_acc6);
    check_eq("ovf6_step", int'(if6.overflow), m_ov6);
    if (m_cnt == 4) begin
      exp_q.push_back('{m_acc8, m_ov8, m_acc6, m_ov6});
      m_run = 1'b0;
    end
  endtask

  task automatic finish_run(input int hold);
    exp_t e;
    int k;
    k = 0;
    while (if8.result_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check_eq("result_latency", k, 0);
    check_eq("result_valid", int'(if8.result_valid), 1);
    check_eq("done_in_ready", int'(if8.in_ready), 0);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q[0];
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("hold_valid", int'(if8.result_valid), 1);
      check_eq("hold_acc8", int'(if8.acc_out), e.acc8);
      check_eq("hold_acc6", int'(if6.acc_out), e.acc6);
    end
    result_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("res_acc8", int'(if8.acc_out), e.acc8);
    check_eq("res_ovf8", int'(if8.overflow), e.ov8);
    check_eq("res_acc6", int'(if6.acc_out), e.acc6);
    check_eq("res_ovf6", int'(if6.overflow), e.ov6);
    tick();
    result_ready = 1'b0;
    check_eq("idle_valid", int'(if8.result_valid), 0);
    check_eq("idle_busy", int'(if6.busy), 0);
    check_eq("idle_acc_held", int'(if8.acc_out), e.acc8);
    check_eq("idle_ovf_held", int'(if6.overflow), e.ov6);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    in_sum = 5'd7;
    result_ready = 1'b0;
    m_run = 1'b0;

    // Reset holds everything idle despite active start/in_valid
    repeat (3) tick();
    check_eq("rst_busy", int'(if8.busy), 0);
    check_eq("rst_in_ready", int'(if8.in_ready), 0);
    check_eq("rst_result_valid", int'(if8.result_valid), 0);
    check_eq("rst_acc", int'(if8.acc_out), 0);
    check_eq("rst_ovf", int'(if8.overflow), 0);
    start = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("post_rst_busy", int'(if8.busy), 0);
    check_eq("post_rst_acc", int'(if8.acc_out), 0);

    // Nominal continuous run: 3+3+7+5 = 18
    do_start();
    send_sample(3, 0);
    send_sample(3, 0);
    send_sample(7, 0);
    send_sample(5, 0);
    finish_run(0);

    // Bubbles between samples and 5 cycles of backpressure: 29
    do_start();
    send_sample(14, 2);
    send_sample(0, 1);
    send_sample(14, 3);
    send_sample(1, 1);
    finish_run(5);

    // Saturation on the 6-bit instance: 30, 60, 63, 63
    do_start();
    send_sample(30, 0);
    send_sample(30, 0);
    send_sample(30, 0);
    check_eq("sat6_value", int'(if6.acc_out), 63);
    check_eq("sat6_ovf", int'(if6.overflow), 1);
    send_sample(0, 0);
    finish_run(1);

    // New start clears sticky overflow
    do_start();
    check_eq("ovf_cleared", int'(if6.overflow), 0);

    // Start ignored mid-run, then asynchronous reset after 3rd sample
    send_sample(10, 0);
    send_sample(10, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ignored_start_acc", int'(if8.acc_out), 20);
    check_eq("ignored_start_busy", int'(if8.busy), 1);
    send_sample(10, 0);
    #2;
    rst_n = 1'b0;
    m_run = 1'b0;
    #1;
    check_eq("midrst_acc", int'(if8.acc_out), 0);
    check_eq("midrst_valid", int'(if8.result_valid), 0);
    check_eq("midrst_busy", int'(if8.busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("midrst_no_result", int'(if8.result_valid), 0);
    check_eq("midrst_queue", exp_q.size(), 0);

    // Clean restart after reset: 1+2+3+4 = 10
    do_start();
    send_sample(1, 0);
    send_sample(2, 0);
    send_sample(3, 1);
    send_sample(4, 0);
    finish_run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
